// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the second-order delta-sigma modulator.
package dsm_pkg;

  typedef logic signed [63:0] acc_wide_t;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic acc_wide_t fs_val(input int unsigned in_w);
    return acc_wide_t'(64'sd1 <<< (in_w - 1));
  endfunction

  function automatic acc_wide_t sat_max(input int unsigned w);
    return acc_wide_t'((64'sd1 <<< (w - 1)) - 64'sd1);
  endfunction

  function automatic acc_wide_t sat_min(input int unsigned w);
    return acc_wide_t'(-(64'sd1 <<< (w - 1)));
  endfunction

endpackage

// File: rtl/dsm_sat_acc.sv
// Saturating accumulator step: sum_o = sat(a + b - c), computed with two guard bits.
module dsm_sat_acc
  import dsm_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [W-1:0] c_i,
  output logic signed [W-1:0] sum_o,
  output logic                sat_o
);

  localparam logic signed [W+1:0] SatHi = (W+2)'(sat_max(W));
  localparam logic signed [W+1:0] SatLo = (W+2)'(sat_min(W));

  logic signed [W+1:0] sum_w;

  always_comb begin
    sum_w = (W+2)'(a_i) + (W+2)'(b_i) - (W+2)'(c_i);
    sum_o = sum_w[W-1:0];
    sat_o = 1'b0;
    if (sum_w > SatHi) begin
      sum_o = SatHi[W-1:0];
      sat_o = 1'b1;
    end else if (sum_w < SatLo) begin
      sum_o = SatLo[W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/dsm2_modulator.sv
// Second-order 1-bit delta-sigma modulator with saturation recovery.
// Define DSM_DITHER_EN to add LFSR dither to the quantizer decision.
module dsm2_modulator
  import dsm_pkg::*;
#(
  parameter int unsigned IN_W      = 20,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned RECOV_CYC = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] v_in,
  output logic            dsm_o,
  output logic            ovf_o,
  output logic            recov_o
);

  localparam logic signed [ACC_W-1:0] Fs       = ACC_W'(fs_val(IN_W));
  localparam logic [9:0]              RecovCnt = 10'(RECOV_CYC);

  logic signed [ACC_W-1:0] x_q, x_d, int1_q, int1_d, int2_q, int2_d;
  logic signed [ACC_W-1:0] int1_sum, int2_sum, fb;
  logic                    dsm_q, dsm_d, ovf_q, ovf_d, recov_q, recov_d;
  logic                    sat1, sat2, sat_any, recov_fire, dsm_dec;
  logic [9:0]              cnt_q, cnt_d;

  assign fb = dsm_q ? Fs : -Fs;

  dsm_sat_acc #(.W(ACC_W)) u_int1 (
    .a_i   (int1_q),
    .b_i   (x_q),
    .c_i   (fb),
    .sum_o (int1_sum),
    .sat_o (sat1)
  );

  // Second stage integrates the old int1 value.
  dsm_sat_acc #(.W(ACC_W)) u_int2 (
    .a_i   (int2_q),
    .b_i   (int1_q),
    .c_i   (fb),
    .sum_o (int2_sum),
    .sat_o (sat2)
  );

`ifdef DSM_DITHER_EN
  logic [15:0]           lfsr_q, lfsr_d;
  logic signed [ACC_W:0] dith, dec_w;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
    dith   = $signed({{(ACC_W-3){1'b0}}, lfsr_q[3:0]}) - $signed((ACC_W+1)'(8));
    dec_w  = (ACC_W+1)'(int2_sum) + dith;
    dsm_dec = ~dec_w[ACC_W];
  end

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LfsrSeed;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign dsm_dec = ~int2_sum[ACC_W-1];
`endif

  assign sat_any    = sat1 | sat2;
  assign recov_fire = (cnt_q == RecovCnt);

  always_comb begin
    x_d     = ACC_W'($signed(v_in));
    int1_d  = int1_sum;
    int2_d  = int2_sum;
    dsm_d   = dsm_dec;
    ovf_d   = ovf_q | sat_any;
    recov_d = 1'b0;
    cnt_d   = sat_any ? ((cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1) : 10'd0;
    // Recovery clear overrides the integrator update, but ovf still latches.
    if (recov_fire) begin
      int1_d  = '0;
      int2_d  = '0;
      dsm_d   = 1'b0;
      cnt_d   = '0;
      recov_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      int1_q  <= '0;
      int2_q  <= '0;
      dsm_q   <= 1'b0;
      ovf_q   <= 1'b0;
      recov_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      x_q     <= x_d;
      int1_q  <= int1_d;
      int2_q  <= int2_d;
      dsm_q   <= dsm_d;
      ovf_q   <= ovf_d;
      recov_q <= recov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dsm_o   = dsm_q;
  assign ovf_o   = ovf_q;
  assign recov_o = recov_q;

endmodule

// File: tb/tb_dsm2_modulator.sv
// Directed bench for dsm2_modulator: two instances (default and ACC_W=22/RECOV_CYC=8)
// compared cycle-by-cycle with a behavioural model, plus density and restart checks.
module tb_dsm2_modulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] v_in  = '0;
  logic        dsm_a, ovf_a, rec_a, dsm_b, ovf_b, rec_b;

  always #5 clock = ~clock;

  dsm2_modulator #(.IN_W(20), .ACC_W(24), .RECOV_CYC(64)) dut_a (
    .clock   (clock),
    .reset   (reset),
    .v_in    (v_in),
    .dsm_o   (dsm_a),
    .ovf_o   (ovf_a),
    .recov_o (rec_a)
  );

  dsm2_modulator #(.IN_W(20), .ACC_W(22), .RECOV_CYC(8)) dut_b (
    .clock   (clock),
    .reset   (reset),
    .v_in    (v_in),
    .dsm_o   (dsm_b),
    .ovf_o   (ovf_b),
    .recov_o (rec_b)
  );

  typedef struct {
    longint      x, i1, i2;
    bit          d, ovf, rec;
    int          cnt;
    logic [15:0] lf;
  } mdl_t;

  mdl_t ma, mb, mh1, mh2;
  int   errors = 0, checks = 0;
  int   mism_a = 0, mism_b = 0, ones = 0, pulses_a = 0, pulses_b = 0, diff = 0;
  logic fresh [200];

  function automatic mdl_t mstep(input mdl_t m, input longint v, input bit rst,
                                 input int accw, input int rc);
    mdl_t   n;
    longint fs, fb, hi, lo, s1, s2;
    bit     st;
    n = m;
    if (rst) begin
      n.x = 0; n.i1 = 0; n.i2 = 0; n.d = 0; n.ovf = 0; n.rec = 0; n.cnt = 0;
      n.lf = 16'hACE1;
      return n;
    end
    fs = longint'(1) << 19;
    fb = m.d ? fs : -fs;
    hi = (longint'(1) << (accw - 1)) - 1;
    lo = -hi - 1;
    s1 = m.i1 + m.x - fb;
    s2 = m.i2 + m.i1 - fb;
    st = 0;
    if (s1 > hi) begin s1 = hi; st = 1; end
    else if (s1 < lo) begin s1 = lo; st = 1; end
    if (s2 > hi) begin s2 = hi; st = 1; end
    else if (s2 < lo) begin s2 = lo; st = 1; end
    n.x   = v;
    n.ovf = m.ovf | st;
    n.lf  = {m.lf[14:0], m.lf[15] ^ m.lf[13] ^ m.lf[12] ^ m.lf[10]};
    if (m.cnt == rc) begin
      n.i1 = 0; n.i2 = 0; n.d = 0; n.cnt = 0; n.rec = 1;
    end else begin
      n.i1  = s1;
      n.i2  = s2;
      n.rec = 0;
      n.cnt = st ? ((m.cnt == 1023) ? 1023 : m.cnt + 1) : 0;
`ifdef DSM_DITHER_EN
      n.d = (s2 + longint'(m.lf[3:0]) - 8) >= 0;
`else
      n.d = (s2 >= 0);
`endif
    end
    return n;
  endfunction

  task automatic cycle(input logic [19:0] v, input bit r);
    v_in  = v;
    reset = r;
    @(posedge clock);
    #1;
    ma = mstep(ma, longint'($signed(v)), r, 24, 64);
    mb = mstep(mb, longint'($signed(v)), r, 22, 8);
    if (dsm_a !== ma.d || ovf_a !== ma.ovf || rec_a !== ma.rec) mism_a++;
    if (dsm_b !== mb.d || ovf_b !== mb.ovf || rec_b !== mb.rec) mism_b++;
    ones     += int'(dsm_a);
    pulses_a += int'(rec_a);
    pulses_b += int'(rec_b);
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input longint obs, input longint lo,
                           input longint hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

`ifdef DSM_DITHER_EN
  localparam int Tol0 = 4, TolH = 4;
`else
  localparam int Tol0 = 2, TolH = 3;
`endif

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) cycle(20'h00000, 1'b1);
    check("rst_dsm_a", dsm_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_rec_a", rec_a, 0);
    check("rst_dsm_b", dsm_b, 0);
    check("rst_ovf_b", ovf_b, 0);

    // Idle input: half density, no overflow or recovery
    pulses_a = 0;
    for (int i = 0; i < 1000; i++) cycle(20'h00000, 1'b0);
    ones = 0;
    for (int i = 0; i < 1000; i++) cycle(20'h00000, 1'b0);
    check_rng("idle_density", ones, 500 - Tol0, 500 + Tol0);
    check("idle_ovf", ovf_a, 0);
    check("idle_recov_pulses", pulses_a, 0);
    check("idle_model_a", mism_a, 0);

    // +FS/2 from fresh reset; keep the first 200 bits for the restart check
    for (int i = 0; i < 2; i++) cycle(20'h00000, 1'b1);
    for (int i = 0; i < 200; i++) begin
      cycle(20'h40000, 1'b0);
      fresh[i] = dsm_a;
    end
    for (int i = 0; i < 64; i++) cycle(20'h40000, 1'b0);
    ones = 0;
    for (int i = 0; i < 1024; i++) cycle(20'h40000, 1'b0);
    check_rng("half_pos_density", ones, 768 - TolH, 768 + TolH);

    // -FS/2
    for (int i = 0; i < 64; i++) cycle(20'hC0000, 1'b0);
    ones = 0;
    for (int i = 0; i < 1024; i++) cycle(20'hC0000, 1'b0);
    check_rng("half_neg_density", ones, 256 - TolH, 256 + TolH);
    check("density_model_a", mism_a, 0);

    // Latency: a step at edge k cannot change dsm_o at k or k+1
    for (int i = 0; i < 300; i++) cycle(20'h00000, 1'b0);
    mh1 = mstep(ma, 0, 1'b0, 24, 64);
    mh2 = mstep(mh1, 0, 1'b0, 24, 64);
    cycle(20'h40000, 1'b0);
    check("lat_edge_k", dsm_a, mh1.d);
    cycle(20'h40000, 1'b0);
    check("lat_edge_k1", dsm_a, mh2.d);
    for (int i = 0; i < 100; i++) cycle(20'h40000, 1'b0);
    check("step_model_a", mism_a, 0);

    // Mid-stream reset must restart the exact fresh sequence
    for (int i = 0; i < 300; i++) cycle(20'h40000, 1'b0);
    cycle(20'h40000, 1'b1);
    check("mid_rst_dsm", dsm_a, 0);
    check("mid_rst_ovf", ovf_a, 0);
    check("mid_rst_rec", rec_a, 0);
    diff = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(20'h40000, 1'b0);
      if (dsm_a !== fresh[i]) diff++;
    end
    check("restart_sequence", diff, 0);

    // Full-scale overload: saturation, sticky ovf, periodic recovery on dut_b
    cycle(20'h00000, 1'b1);
    pulses_b = 0;
    for (int i = 0; i < 5000; i++) cycle(20'h7FFFF, 1'b0);
    check("ovl_ovf_b", ovf_b, 1);
    check_rng("ovl_recov_pulses_b", pulses_b, 1, 5000);
    check("ovl_model_b", mism_b, 0);
    check("final_model_a", mism_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
